shm_button_events: RTL and testbench

SHM_BUTTON_EVENTS -- requirements
Module: shm_button_events

---
 rtl/shm_button_events.sv | 259 +++++++++++++++++++++++++
 tb/tb_shm_button_events.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/shm_button_events.sv
// Scroll HAT Mini button event generator. Each button produces PRESS/RELEASE/LONG/REPEAT
// events into a one-deep pending slot; a fixed-priority arbiter moves them into an event FIFO.

module shm_button_fsm #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key,
    input  logic       key_q,
    output logic       gen_vld,
    output logic [1:0] gen_type
);
    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_RELEASE = 2'd1;
    localparam logic [1:0] EV_LONG    = 2'd2;
    localparam logic [1:0] EV_REPEAT  = 2'd3;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DOWN, S_HELD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise, fall;

    assign rise = key & ~key_q;
    assign fall = ~key & key_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_DOWN;
                    cnt_d   = '0;
                end
            end
            S_DOWN: begin
                if (fall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (key) begin
                    if (cnt_q == LONG_LAST) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_HELD: begin
                if (fall) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (key) begin
                    cnt_d = (cnt_q == REPEAT_LAST) ? '0 : cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A release on the same cycle as a LONG/REPEAT wins
    always_comb begin
        gen_vld  = 1'b0;
        gen_type = EV_PRESS;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    gen_vld  = 1'b1;
                    gen_type = EV_PRESS;
                end
            end
            S_DOWN: begin
                if (fall) begin
                    gen_vld  = 1'b1;
                    gen_type = EV_RELEASE;
                end else if (key && cnt_q == LONG_LAST) begin
                    gen_vld  = 1'b1;
                    gen_type = EV_LONG;
                end
            end
            S_HELD: begin
                if (fall) begin
                    gen_vld  = 1'b1;
                    gen_type = EV_RELEASE;
                end else if (key && cnt_q == REPEAT_LAST) begin
                    gen_vld  = 1'b1;
                    gen_type = EV_REPEAT;
                end
            end
            default: begin
                gen_vld  = 1'b0;
                gen_type = EV_PRESS;
            end
        endcase
    end
endmodule

module shm_button_events #(
    parameter int  NUM_KEYS      = 4,
    parameter int  LONG_CYCLES   = 50_000_000,
    parameter int  REPEAT_CYCLES = 10_000_000,
    parameter int  FIFO_DEPTH    = 8,
    localparam int BTN_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int EVT_W         = BTN_W + 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [EVT_W-1:0]    evt_data,
    output logic [NUM_KEYS-1:0] held,
    output logic                overflow,
    input  logic                overflow_clr
);
    localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HCNT_W  = $clog2(MAX_CYC) + 1;
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic [NUM_KEYS-1:0]              key_q, key_d;
    logic [NUM_KEYS-1:0]              gen_vld;
    logic [NUM_KEYS-1:0][1:0]         gen_type;
    logic [NUM_KEYS-1:0]              pend_vld_q, pend_vld_d;
    logic [NUM_KEYS-1:0][1:0]         pend_type_q, pend_type_d;
    logic [NUM_KEYS-1:0]              grant, drop;
    logic [BTN_W-1:0]                 arb_idx;
    logic                             arb_any;
    logic                             push, pop, fifo_full;
    logic [EVT_W-1:0]                 push_data;
    logic [FIFO_DEPTH-1:0][EVT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;
    logic                             overflow_q, overflow_d;

    assign key_d = key;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_btn
        shm_button_fsm #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (HCNT_W)
        ) u_fsm (
            .clk      (clk),
            .reset    (reset),
            .key      (key[g]),
            .key_q    (key_q[g]),
            .gen_vld  (gen_vld[g]),
            .gen_type (gen_type[g])
        );
    end

    // Descending scan so the lowest occupied index is the one left in arb_idx
    always_comb begin
        arb_any = 1'b0;
        arb_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend_vld_q[i]) begin
                arb_any = 1'b1;
                arb_idx = BTN_W'(i);
            end
        end
    end

    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign push      = arb_any & ~fifo_full;
    assign push_data = {pend_type_q[arb_idx], arb_idx};
    assign pop       = evt_valid & evt_ready;

    always_comb begin
        grant       = '0;
        drop        = '0;
        pend_vld_d  = pend_vld_q;
        pend_type_d = pend_type_q;
        if (push) grant[arb_idx] = 1'b1;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (grant[i]) pend_vld_d[i] = 1'b0;
            if (gen_vld[i]) begin
                if (pend_vld_q[i] && !grant[i]) begin
                    drop[i] = 1'b1;
                end else begin
                    pend_vld_d[i]  = 1'b1;
                    pend_type_d[i] = gen_type[i];
                end
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (overflow_clr) overflow_d = 1'b0;
        if (|drop) overflow_d = 1'b1;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q       <= '0;
            pend_vld_q  <= '0;
            pend_type_q <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            key_q       <= key_d;
            pend_vld_q  <= pend_vld_d;
            pend_type_q <= pend_type_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_data  = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign held      = key_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_shm_button_events.sv
// Bench for shm_button_events: table of hold patterns with expected event streams and
// arrival cycles, plus hand-written backpressure, overflow and reset sequences.

module tb_shm_button_events;
    localparam int NK = 4;
    localparam int LC = 10;
    localparam int RC = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key;
    logic          evt_valid;
    logic          evt_ready;
    logic [3:0]    evt_data;
    logic [NK-1:0] held;
    logic          overflow;
    logic          overflow_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shm_button_events #(
        .NUM_KEYS      (NK),
        .LONG_CYCLES   (LC),
        .REPEAT_CYCLES (RC),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key          (key),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_data     (evt_data),
        .held         (held),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // at < 0 means arrival cycle is not checked
    typedef struct packed {
        logic [3:0] data;
        int         at;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic [3:0]       mask;
        int               hold;
        int               n;
        logic [7:0][3:0]  d;
        logic [7:0][7:0]  off;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_ev(input int r, input logic [3:0] d, input int off);
        vecs[r].d[vecs[r].n]   = d;
        vecs[r].off[vecs[r].n] = 8'(off);
        vecs[r].n              = vecs[r].n + 1;
    endtask

    task automatic new_vec(input int r, input logic [3:0] mask, input int hold);
        vecs[r] = '{mask: mask, hold: hold, n: 0, d: '0, off: '0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int i;
        i = 0;
        while (sb.size() != 0 && i < limit) begin
            step();
            i++;
        end
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    // Scoreboard: compare every accepted head event against the queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && evt_valid && evt_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got 0x%0h with nothing expected (cycle %0d)", evt_data, cyc);
            end else begin
                e = sb.pop_front();
                if (evt_data !== e.data || (e.at >= 0 && cyc != e.at)) begin
                    errors++;
                    $display("FAIL event: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                             evt_data, cyc, e.data, e.at);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic run_vec(input int r);
        int k0;
        k0  = cyc;
        key = vecs[r].mask;
        for (int k = 0; k < vecs[r].n; k++)
            sb.push_back('{data: vecs[r].d[k], at: k0 + int'(vecs[r].off[k])});
        for (int h = 0; h < vecs[r].hold; h++) begin
            step();
            if (h == 0) chk($sformatf("held_row%0d", r), 32'(held), 32'(vecs[r].mask));
        end
        key = '0;
        wait_drain($sformatf("drain_row%0d", r), 60);
        repeat (3) step();
    endtask

    initial begin
        int k0;
        reset        = 1'b1;
        key          = '0;
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;

        // Offsets count edges from the drive point; the edge sampling the key is offset 1
        new_vec(0, 4'b0010, 3);  add_ev(0, 4'h1, 2);  add_ev(0, 4'h5, 5);
        new_vec(1, 4'b0001, 20); add_ev(1, 4'h0, 2);  add_ev(1, 4'h8, 12);
                                 add_ev(1, 4'hC, 16); add_ev(1, 4'hC, 20); add_ev(1, 4'h4, 22);
        new_vec(2, 4'b0100, 10); add_ev(2, 4'h2, 2);  add_ev(2, 4'h6, 12);
        new_vec(3, 4'b1000, 11); add_ev(3, 4'h3, 2);  add_ev(3, 4'hB, 12); add_ev(3, 4'h7, 13);
        new_vec(4, 4'b0010, 15); add_ev(4, 4'h1, 2);  add_ev(4, 4'h9, 12);
                                 add_ev(4, 4'hD, 16); add_ev(4, 4'h5, 17);
        new_vec(5, 4'b1111, 5);  add_ev(5, 4'h0, 2);  add_ev(5, 4'h1, 3);
                                 add_ev(5, 4'h2, 4);  add_ev(5, 4'h3, 5);
                                 add_ev(5, 4'h4, 7);  add_ev(5, 4'h5, 8);
                                 add_ev(5, 4'h6, 9);  add_ev(5, 4'h7, 10);
        new_vec(6, 4'b0001, 1);  add_ev(6, 4'h0, 2);  add_ev(6, 4'h4, 3);

        repeat (3) @(posedge clk);
        key = 4'b0101;
        @(negedge clk);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_data", 32'(evt_data), 0);
        chk("rst_held", 32'(held), 0);
        chk("rst_overflow", 32'(overflow), 0);
        key = '0;
        step();
        reset = 1'b0;
        repeat (2) step();

        for (int r = 0; r < 7; r++) run_vec(r);
        chk("no_overflow_after_table", 32'(overflow), 0);

        // Backpressure: four press/release pairs with the consumer stalled
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            key = 4'b0100;
            step();
            key = '0;
            step();
        end
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(evt_valid), 1);
            chk("bp_data_stable", 32'(evt_data), 32'h2);
        end
        chk("bp_overflow", 32'(overflow), 1);

        step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        key          = 4'b0100;
        overflow_clr = 1'b1;
        step();
        chk("ovf_drop_beats_clr", 32'(overflow), 1);
        key          = '0;
        overflow_clr = 1'b0;
        step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_cleared_again", 32'(overflow), 0);

        sb.push_back('{data: 4'h2, at: -1});
        sb.push_back('{data: 4'h6, at: -1});
        sb.push_back('{data: 4'h2, at: -1});
        sb.push_back('{data: 4'h6, at: -1});
        sb.push_back('{data: 4'h2, at: -1});
        evt_ready = 1'b1;
        wait_drain("drain_bp", 20);
        repeat (3) step();
        chk("bp_empty", 32'(evt_valid), 0);

        // Reset mid-hold with a non-empty FIFO
        evt_ready = 1'b0;
        key       = 4'b1000;
        repeat (4) step();
        chk("pre_reset_valid", 32'(evt_valid), 1);
        reset = 1'b1;
        step();
        chk("reset_valid", 32'(evt_valid), 0);
        chk("reset_held", 32'(held), 0);
        k0        = cyc;
        reset     = 1'b0;
        evt_ready = 1'b1;
        sb.push_back('{data: 4'h3, at: k0 + 2});
        repeat (3) step();
        key = '0;
        sb.push_back('{data: 4'h7, at: -1});
        wait_drain("drain_post_reset", 20);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
